// File: rtl/systolic_addr_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_addr_ctrl_if
//
// Job handshake, fetch control and operand address bus of the systolic-array
// operand-fetch controller.
//   master : host side. Drives start, order and stall.
//   slave  : controller side. Drives addresses, fetch strobes and job status.
//
// Signals
//   start       host -> ctrl  one-cycle job request (honoured only when idle)
//   order       host -> ctrl  tile loop order, sampled with start
//   stall       host -> ctrl  fetch back-pressure
//   rd_addr_A   ctrl -> host  A tile-memory address (rt*K + k)
//   rd_addr_B   ctrl -> host  B tile-memory address (ct*K + k)
//   rd_valid    ctrl -> host  a fetch is issued this cycle
//   tile_first  ctrl -> host  fetch with k == 0 (accumulator clear)
//   tile_last   ctrl -> host  fetch with k == K-1 (result capture)
//   tile_row    ctrl -> host  current row-tile index rt
//   tile_col    ctrl -> host  current col-tile index ct
//   busy        ctrl -> host  job in progress
//   done        ctrl -> host  one-cycle end-of-job pulse
//
// The width parameters must equal the derived widths of the attached
// controller instance.
// -----------------------------------------------------------------------------
interface systolic_addr_ctrl_if #(
    parameter int AW_A = 6,
    parameter int AW_B = 5,
    parameter int TRW  = 2,
    parameter int TCW  = 1
);
    logic            start;
    logic            order;
    logic            stall;
    logic [AW_A-1:0] rd_addr_A;
    logic [AW_B-1:0] rd_addr_B;
    logic            rd_valid;
    logic            tile_first;
    logic            tile_last;
    logic [TRW-1:0]  tile_row;
    logic [TCW-1:0]  tile_col;
    logic            busy;
    logic            done;

    modport master (
        output start, order, stall,
        input  rd_addr_A, rd_addr_B, rd_valid, tile_first, tile_last,
        input  tile_row, tile_col, busy, done
    );

    modport slave (
        input  start, order, stall,
        output rd_addr_A, rd_addr_B, rd_valid, tile_first, tile_last,
        output tile_row, tile_col, busy, done
    );
endinterface

// File: rtl/systolic_addr_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_addr_ctrl
//
// Operand-fetch controller for an N1 x N2 systolic array computing the
// rectangular GEMM C[M x P] = A[M x K] * B[K x P]. For every (row-tile,
// col-tile) pair it issues K consecutive fetches, addressing the A memory at
// rt*K + k and the B memory at ct*K + k. The tile loop order is selectable per
// job. After the last fetch the controller waits out the array skew (plus any
// downstream pipeline depth) before pulsing done.
//
// Ports
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-low reset
//   bus  : systolic_addr_ctrl_if.slave (handshake, stall, addresses, status)
//
// Sequence: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module systolic_addr_ctrl #(
    parameter int N1          = 4,   // array rows
    parameter int N2          = 8,   // array columns
    parameter int M           = 16,  // rows of A / C, multiple of N1
    parameter int K           = 16,  // inner dimension, >= 2
    parameter int P           = 16,  // columns of B / C, multiple of N2
    parameter int EXTRA_DRAIN = 0    // downstream pipeline depth
) (
    input logic                 clk,
    input logic                 rst,
    systolic_addr_ctrl_if.slave bus
);
    localparam int RT    = M / N1;
    localparam int CT    = P / N2;
    localparam int AW_A  = (RT * K > 1) ? $clog2(RT * K) : 1;
    localparam int AW_B  = (CT * K > 1) ? $clog2(CT * K) : 1;
    localparam int TRW   = (RT > 1) ? $clog2(RT) : 1;
    localparam int TCW   = (CT > 1) ? $clog2(CT) : 1;
    localparam int KW    = $clog2(K);
    localparam int DRAIN = N1 + N2 - 2 + EXTRA_DRAIN;
    localparam int DCW   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
    localparam logic [TRW-1:0] RT_MAX = TRW'(RT - 1);
    localparam logic [TCW-1:0] CT_MAX = TCW'(CT - 1);
    localparam logic [DCW-1:0] D_MAX  = DCW'((DRAIN > 0) ? DRAIN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [KW-1:0]  k_cnt;
    logic [TRW-1:0] rt_cnt;
    logic [TCW-1:0] ct_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           order_q;   // 0: ct is the inner tile loop, 1: rt is

    logic fetch;
    logic k_wrap;
    logic rt_wrap;
    logic ct_wrap;
    logic last_fetch;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every register uses non-blocking assignment so all flops sample
    // the pre-edge values and the process order does not matter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and fetch decode
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        fetch      = 1'b0;
        k_wrap     = (k_cnt == K_MAX);
        rt_wrap    = (rt_cnt == RT_MAX);
        ct_wrap    = (ct_cnt == CT_MAX);
        last_fetch = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                fetch      = !bus.stall;
                last_fetch = fetch && k_wrap && rt_wrap && ct_wrap;
                if (last_fetch) begin
                    // With no skew to flush the drain phase is skipped.
                    state_nxt = (DRAIN == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == D_MAX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Loop counters
    // -------------------------------------------------------------------------
    // k is always innermost. On a k wrap the inner tile counter steps; on an
    // inner wrap the outer one steps. After the final fetch everything has
    // wrapped back to zero, so the idle address outputs read 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_cnt     <= '0;
            rt_cnt    <= '0;
            ct_cnt    <= '0;
            drain_cnt <= '0;
            order_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                k_cnt   <= '0;
                rt_cnt  <= '0;
                ct_cnt  <= '0;
                order_q <= bus.order;
            end else if (fetch) begin
                if (!k_wrap) begin
                    k_cnt <= k_cnt + KW'(1);
                end else begin
                    k_cnt <= '0;
                    if (!order_q) begin
                        if (!ct_wrap) begin
                            ct_cnt <= ct_cnt + TCW'(1);
                        end else begin
                            ct_cnt <= '0;
                            rt_cnt <= rt_wrap ? '0 : rt_cnt + TRW'(1);
                        end
                    end else begin
                        if (!rt_wrap) begin
                            rt_cnt <= rt_cnt + TRW'(1);
                        end else begin
                            rt_cnt <= '0;
                            ct_cnt <= ct_wrap ? '0 : ct_cnt + TCW'(1);
                        end
                    end
                end
            end

            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Addresses are pure functions of the registered counters, so they hold
    // their value through a stall. K is a constant, so the product is a shift
    // or small constant multiply.
    assign bus.rd_addr_A  = AW_A'(32'(rt_cnt) * K + 32'(k_cnt));
    assign bus.rd_addr_B  = AW_B'(32'(ct_cnt) * K + 32'(k_cnt));
    assign bus.rd_valid   = fetch;
    assign bus.tile_first = fetch && (k_cnt == '0);
    assign bus.tile_last  = fetch && k_wrap;
    assign bus.tile_row   = rt_cnt;
    assign bus.tile_col   = ct_cnt;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);

endmodule
